// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared types and defaults for the memory wait bridge.
// Holds the FSM state encoding and the default WIDTH / TIMEOUT values.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/mem_wait_bridge_ctr.sv
// bus_timeout_ctr: counts REQ cycles without ack; expired flags the last one.
// Ports: clk, rst (async high), clear, enable, expired.
module bus_timeout_ctr
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of ack-less REQ cycles already completed,
  // so the cycle seeing TIMEOUT-1 is the TIMEOUT-th waiting cycle.
  assign expired = enable && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_wait_bridge.sv
// mem_wait_bridge: stalls a single-cycle core while a wait-state bus completes.
// Ports: core side memread/memwrite/adr/writedata -> memdata/stall;
// bus side bus_req/bus_we/bus_addr/bus_wdata, bus_rdata/bus_ack in, bus_err.
// Optional timeout abort enabled by defining MEM_TIMEOUT_EN.
module mem_wait_bridge
  import mem_bridge_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  output logic             stall,
  output logic             bus_req,
  output logic             bus_we,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic [WIDTH-1:0] bus_rdata,
  input  logic             bus_ack,
  output logic             bus_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t           state;
  logic [WIDTH-1:0] rdata_q;
  logic             start;
  logic             expired;

  assign start   = (state == IDLE) && (memread || memwrite);
  assign stall   = start || (state == REQ);
  assign memdata = rdata_q;

`ifdef MEM_TIMEOUT_EN
  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .enable  ((state == REQ) && !bus_ack),
    .expired (expired)
  );

  // Sticky: only a reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if (expired) begin
      bus_err <= 1'b1;
    end
  end
`else
  assign expired = 1'b0;
  assign bus_err = 1'b0;
`endif

  // bus_addr / bus_wdata double as the latched request registers;
  // bus_we doubles as the latched write flag while in REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memread || memwrite) begin
            bus_addr  <= adr;
            bus_wdata <= writedata;
            bus_we    <= memwrite;
            bus_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          // ack wins over a coincident timeout.
          if (bus_ack) begin
            if (!bus_we) rdata_q <= bus_rdata;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            state   <= DONE;
          end else if (expired) begin
            if (!bus_we) rdata_q <= '1;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          bus_req <= 1'b0;
          bus_we  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wait_bridge.sv
// tb_mem_wait_bridge: directed vector table plus hand-written sequences
// for reset-in-flight and timeout behaviour of mem_wait_bridge.
module tb_mem_wait_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       memread = 1'b0;
  logic       memwrite = 1'b0;
  logic [7:0] adr = 8'h00;
  logic [7:0] writedata = 8'h00;
  logic [7:0] memdata;
  logic       stall;
  logic       bus_req;
  logic       bus_we;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata = 8'h00;
  logic       bus_ack = 1'b0;
  logic       bus_err;

  int checks = 0;
  int errors = 0;

  mem_wait_bridge #(
    .WIDTH   (8),
    .TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memread   (memread),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .memdata   (memdata),
    .stall     (stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] wd;
    logic       ack;
    logic [7:0] rdt;
    logic       stall;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] mdata;
  } vec_t;

  vec_t tbl[23];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One core cycle: drive at negedge, settle, caller then samples.
  task automatic step(input logic rd, input logic wr, input logic [7:0] a,
                      input logic [7:0] wd, input logic ack,
                      input logic [7:0] rdt);
    @(negedge clk);
    memread   = rd;
    memwrite  = wr;
    adr       = a;
    writedata = wd;
    bus_ack   = ack;
    bus_rdata = rdt;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rd    wr    adr    wdata  ack   rdata  stall req   we    addr   wdata  memdata
    tbl[0]  = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
    tbl[4]  = '{1'b0, 1'b1, 8'h3C, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
    tbl[5]  = '{1'b0, 1'b1, 8'h3C, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 8'h5A, 8'hA5};
    tbl[6]  = '{1'b0, 1'b1, 8'h3C, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 8'h5A, 8'hA5};
    tbl[7]  = '{1'b0, 1'b1, 8'h3C, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 8'h5A, 8'hA5};
    tbl[8]  = '{1'b0, 1'b1, 8'h3C, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 8'h5A, 8'hA5};
    tbl[9]  = '{1'b0, 1'b1, 8'h3C, 8'h5A, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h3C, 8'h5A, 8'hA5};
    tbl[10] = '{1'b0, 1'b0, 8'h3C, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h5A, 8'hA5};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h5A, 8'hA5};
    tbl[12] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h5A, 8'hA5};
    tbl[13] = '{1'b1, 1'b1, 8'h20, 8'h99, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
    tbl[14] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
    tbl[15] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h3C};
    tbl[16] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h3C};
    tbl[17] = '{1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 8'hC3};
    tbl[19] = '{1'b1, 1'b1, 8'h44, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 8'hC3};
    tbl[20] = '{1'b0, 1'b0, 8'h44, 8'h77, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 8'h77, 8'hC3};
    tbl[21] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h44, 8'h77, 8'hC3};
    tbl[22] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h44, 8'h77, 8'hC3};

    // Reset state, sampled while rst is held.
    #2;
    chk1("rst.stall", stall, 1'b0);
    chk1("rst.bus_req", bus_req, 1'b0);
    chk1("rst.bus_we", bus_we, 1'b0);
    chk8("rst.bus_addr", bus_addr, 8'h00);
    chk8("rst.bus_wdata", bus_wdata, 8'h00);
    chk8("rst.memdata", memdata, 8'h00);
    chk1("rst.bus_err", bus_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].ack, tbl[i].rdt);
      chk1($sformatf("v%0d.stall", i), stall, tbl[i].stall);
      chk1($sformatf("v%0d.bus_req", i), bus_req, tbl[i].req);
      chk1($sformatf("v%0d.bus_we", i), bus_we, tbl[i].we);
      chk8($sformatf("v%0d.bus_addr", i), bus_addr, tbl[i].addr);
      chk8($sformatf("v%0d.bus_wdata", i), bus_wdata, tbl[i].wdata);
      chk8($sformatf("v%0d.memdata", i), memdata, tbl[i].mdata);
      chk1($sformatf("v%0d.bus_err", i), bus_err, 1'b0);
    end

    // Reset pulsed between edges while a read waits in REQ.
    step(1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk1("mid.req_before", bus_req, 1'b1);
    chk8("mid.addr_before", bus_addr, 8'h55);
    #1;
    rst = 1'b1;
    #1;
    chk1("mid.bus_req", bus_req, 1'b0);
    chk1("mid.stall", stall, 1'b0);
    chk8("mid.memdata", memdata, 8'h00);
    chk8("mid.bus_addr", bus_addr, 8'h00);
    rst = 1'b0;
    step(1'b1, 1'b0, 8'h66, 8'h00, 1'b0, 8'h00);
    chk1("post.stall_idle", stall, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h9D);
    chk1("post.bus_req", bus_req, 1'b1);
    chk8("post.bus_addr", bus_addr, 8'h66);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk1("post.stall_done", stall, 1'b0);
    chk8("post.memdata", memdata, 8'h9D);

`ifdef MEM_TIMEOUT_EN
    // Ack in the 15th REQ cycle beats the timeout.
    step(1'b1, 1'b0, 8'h21, 8'h00, 1'b0, 8'h00);
    for (int k = 1; k <= 14; k++) begin
      step(1'b1, 1'b0, 8'h21, 8'h00, 1'b0, 8'h00);
      chk1($sformatf("race.req%0d", k), bus_req, 1'b1);
    end
    step(1'b1, 1'b0, 8'h21, 8'h00, 1'b1, 8'h5C);
    chk1("race.req15", bus_req, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk1("race.stall_done", stall, 1'b0);
    chk8("race.memdata", memdata, 8'h5C);
    chk1("race.bus_err", bus_err, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);

    // No ack at all: abort after 15 REQ cycles.
    step(1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 8'h00);
    for (int k = 1; k <= 15; k++) begin
      step(1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 8'h00);
      chk1($sformatf("to.req%0d", k), bus_req, 1'b1);
      chk1($sformatf("to.stall%0d", k), stall, 1'b1);
    end
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk1("to.stall_done", stall, 1'b0);
    chk1("to.bus_req_done", bus_req, 1'b0);
    chk8("to.memdata", memdata, 8'hFF);
    chk1("to.bus_err", bus_err, 1'b1);
    step(1'b1, 1'b0, 8'h13, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h42);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk8("to.memdata_next", memdata, 8'h42);
    chk1("to.bus_err_sticky", bus_err, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk1("to.bus_err_rst", bus_err, 1'b0);
    rst = 1'b0;
`else
    // Without the timeout, REQ waits indefinitely.
    step(1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 8'h00);
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 8'h00);
      chk1($sformatf("wait.req%0d", k), bus_req, 1'b1);
      chk1($sformatf("wait.err%0d", k), bus_err, 1'b0);
    end
    step(1'b1, 1'b0, 8'h12, 8'h00, 1'b1, 8'h6B);
    chk1("wait.stall_last", stall, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk1("wait.stall_done", stall, 1'b0);
    chk8("wait.memdata", memdata, 8'h6B);
    chk1("wait.bus_err", bus_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
